// File: rtl/frog_motion_ctrl.sv
// Frogger frog controller: grid movement, log drift, goals, lives and game-over.
// Single clock domain, asynchronous active-low reset.
module frog_motion_ctrl #(
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 15,
    parameter int COORD_W    = 6,
    parameter int START_X    = 10,
    parameter int START_Y    = 14,
    parameter int SCORE_W    = 7,
    parameter int LIVES      = 3,
    parameter int DRIFT_DIV  = 39000000,
    parameter int DEATH_HOLD = 25000000,
    parameter int GOAL_CODE  = 4,
    parameter int WATER_CODE = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Up_Mvt,
    input  logic               i_Down_Mvt,
    input  logic               i_Left_Mvt,
    input  logic               i_Right_Mvt,
    input  logic               i_Restart,
    input  logic               i_Collided,
    input  logic               i_On_Log,
    input  logic               i_Log_Dir,
    input  logic [3:0]         i_Bitmap_Data,
    output logic [COORD_W-1:0] o_Frogger_X,
    output logic [COORD_W-1:0] o_Frogger_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_Lives,
    output logic               o_Dying,
    output logic               o_Game_Over,
    output logic               o_Goal_Pulse
);

    localparam int DRIFT_CW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
    localparam int HOLD_CW  = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;

    localparam logic [COORD_W-1:0]  X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]  Y_START = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0]  X_MAX   = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0]  Y_MAX   = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0]  C_ONE   = COORD_W'(1);
    localparam logic [SCORE_W-1:0]  S_ONE   = SCORE_W'(1);
    localparam logic [DRIFT_CW-1:0] D_ONE   = DRIFT_CW'(1);
    localparam logic [DRIFT_CW-1:0] D_LAST  = DRIFT_CW'(DRIFT_DIV - 1);
    localparam logic [HOLD_CW-1:0]  H_ONE   = HOLD_CW'(1);
    localparam logic [HOLD_CW-1:0]  H_LAST  = HOLD_CW'(DEATH_HOLD - 1);
    localparam logic [2:0]          L_INIT  = 3'(LIVES);
    localparam logic [3:0]          GOAL    = 4'(GOAL_CODE);
    localparam logic [3:0]          WATER   = 4'(WATER_CODE);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        DYING = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [COORD_W-1:0]  x, y, x_nx, y_nx, mx, my, dx;
    logic [SCORE_W-1:0]  score, score_nx;
    logic [2:0]          lives, lives_nx;
    logic [DRIFT_CW-1:0] drift_cnt, drift_nx;
    logic [HOLD_CW-1:0]  hold_cnt, hold_nx;
    logic                pulse, pulse_nx;

    logic up_q, down_q, left_q, right_q, restart_q;
    logic up_ev, down_ev, left_ev, right_ev, restart_ev;
    logic death, goal, tick, hold_done;

    assign up_ev      = i_Up_Mvt & ~up_q;
    assign down_ev    = i_Down_Mvt & ~down_q;
    assign left_ev    = i_Left_Mvt & ~left_q;
    assign right_ev   = i_Right_Mvt & ~right_q;
    assign restart_ev = i_Restart & ~restart_q;

    assign death = i_Collided
                 | ((i_Bitmap_Data == WATER) & ~i_On_Log)
                 | ((y == '0) & (i_Bitmap_Data != GOAL));
    assign goal      = (y == '0) & (i_Bitmap_Data == GOAL);
    assign tick      = i_On_Log & (drift_cnt == D_LAST);
    assign hold_done = (hold_cnt == H_LAST);

    // Edge registers start high so a level held through reset is not a press.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            up_q      <= 1'b1;
            down_q    <= 1'b1;
            left_q    <= 1'b1;
            right_q   <= 1'b1;
            restart_q <= 1'b1;
        end else begin
            up_q      <= i_Up_Mvt;
            down_q    <= i_Down_Mvt;
            left_q    <= i_Left_Mvt;
            right_q   <= i_Right_Mvt;
            restart_q <= i_Restart;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= PLAY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            PLAY:    if (death) state_nx = DYING;
            DYING:   if (hold_done) state_nx = (lives == '0) ? OVER : PLAY;
            OVER:    if (restart_ev) state_nx = PLAY;
            default: state_nx = PLAY;
        endcase
    end

    // Clamped move first, then the wrapping drift on top of it.
    always_comb begin
        mx = x;
        my = y;
        if (up_ev) begin
            if (y != '0) my = y - C_ONE;
        end else if (down_ev) begin
            if (y != Y_MAX) my = y + C_ONE;
        end else if (left_ev) begin
            if (x != '0) mx = x - C_ONE;
        end else if (right_ev) begin
            if (x != X_MAX) mx = x + C_ONE;
        end
        dx = mx;
        if (tick) begin
            if (i_Log_Dir) dx = (mx == X_MAX) ? '0 : mx + C_ONE;
            else           dx = (mx == '0) ? X_MAX : mx - C_ONE;
        end
    end

    always_comb begin
        x_nx     = x;
        y_nx     = y;
        score_nx = score;
        lives_nx = lives;
        drift_nx = drift_cnt;
        hold_nx  = hold_cnt;
        pulse_nx = 1'b0;
        unique case (state)
            PLAY: begin
                if (death) begin
                    lives_nx = lives - 3'd1;
                    hold_nx  = '0;
                end else if (goal) begin
                    score_nx = (score == '1) ? score : score + S_ONE;
                    pulse_nx = 1'b1;
                    x_nx     = X_START;
                    y_nx     = Y_START;
                    drift_nx = '0;
                end else begin
                    x_nx     = dx;
                    y_nx     = my;
                    drift_nx = (!i_On_Log || tick) ? '0 : drift_cnt + D_ONE;
                end
            end
            DYING: begin
                hold_nx = hold_cnt + H_ONE;
                if (hold_done) begin
                    hold_nx = '0;
                    if (lives != '0) begin
                        x_nx     = X_START;
                        y_nx     = Y_START;
                        drift_nx = '0;
                    end
                end
            end
            OVER: begin
                if (restart_ev) begin
                    score_nx = '0;
                    lives_nx = L_INIT;
                    x_nx     = X_START;
                    y_nx     = Y_START;
                    drift_nx = '0;
                    hold_nx  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            x         <= X_START;
            y         <= Y_START;
            score     <= '0;
            lives     <= L_INIT;
            drift_cnt <= '0;
            hold_cnt  <= '0;
            pulse     <= 1'b0;
        end else begin
            x         <= x_nx;
            y         <= y_nx;
            score     <= score_nx;
            lives     <= lives_nx;
            drift_cnt <= drift_nx;
            hold_cnt  <= hold_nx;
            pulse     <= pulse_nx;
        end
    end

    always_comb begin
        o_Dying     = (state == DYING);
        o_Game_Over = (state == OVER);
    end

    assign o_Frogger_X  = x;
    assign o_Frogger_Y  = y;
    assign o_Score      = score;
    assign o_Lives      = lives;
    assign o_Goal_Pulse = pulse;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed bench for frog_motion_ctrl on a small 8x6 grid with
// fast drift/hold so every behaviour is reached in a few thousand cycles.
module tb_frog_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       restart = 1'b0, collided = 1'b0, on_log = 1'b0, log_dir = 1'b0;
    logic [3:0] tile = 4'd0;
    logic [3:0] fx, fy;
    logic [6:0] score;
    logic [2:0] lives;
    logic       dying, over, pulse;

    int checks = 0;
    int errors = 0;

    frog_motion_ctrl #(
        .GRID_W(8), .GRID_H(6), .COORD_W(4), .START_X(4), .START_Y(5),
        .SCORE_W(7), .LIVES(2), .DRIFT_DIV(4), .DEATH_HOLD(3),
        .GOAL_CODE(4), .WATER_CODE(2)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Up_Mvt(up), .i_Down_Mvt(down),
        .i_Left_Mvt(left), .i_Right_Mvt(right),
        .i_Restart(restart), .i_Collided(collided),
        .i_On_Log(on_log), .i_Log_Dir(log_dir),
        .i_Bitmap_Data(tile),
        .o_Frogger_X(fx), .o_Frogger_Y(fy),
        .o_Score(score), .o_Lives(lives),
        .o_Dying(dying), .o_Game_Over(over),
        .o_Goal_Pulse(pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            default: right = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step();
        set_btn(b, 1'b0);
        step();
    endtask

    task automatic climb(input int n);
        for (int i = 0; i < n; i++) press(0);
    endtask

    // From row 5 with goal tile: ends just after the goal edge.
    task automatic goal_run();
        climb(4);
        up = 1'b1;
        step();
        up = 1'b0;
        step();
    endtask

    initial begin
        up = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_x", 32'(fx), 4);
        chk("rst_y", 32'(fy), 5);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 2);
        chk("rst_dying", 32'(dying), 0);
        chk("rst_over", 32'(over), 0);
        chk("rst_pulse", 32'(pulse), 0);
        rst_n = 1'b1;
        step();
        chk("held_up_no_move", 32'(fy), 5);
        up = 1'b0;
        step();

        tile = 4'd4;
        press(0); chk("up_y4", 32'(fy), 4);
        press(0); chk("up_y3", 32'(fy), 3);
        press(0); chk("up_y2", 32'(fy), 2);
        press(0); chk("up_y1", 32'(fy), 1);
        up = 1'b1;
        step();
        chk("up_y0", 32'(fy), 0);
        chk("pre_goal_score", 32'(score), 0);
        up = 1'b0;
        step();
        chk("goal_score", 32'(score), 1);
        chk("goal_pulse", 32'(pulse), 1);
        chk("goal_respawn_x", 32'(fx), 4);
        chk("goal_respawn_y", 32'(fy), 5);
        step();
        chk("goal_pulse_end", 32'(pulse), 0);
        tile = 4'd0;

        press(3); press(3); press(3);
        chk("right_x7", 32'(fx), 7);
        press(3);
        chk("right_clamp", 32'(fx), 7);
        on_log = 1'b1; log_dir = 1'b1;
        step(); step(); step();
        chk("drift_wait", 32'(fx), 7);
        step();
        chk("drift_wrap_pos", 32'(fx), 0);
        log_dir = 1'b0;
        step(); step(); step();
        chk("drift_wait_neg", 32'(fx), 0);
        step();
        chk("drift_wrap_neg", 32'(fx), 7);
        step(); step(); step();
        on_log = 1'b0;
        step();
        chk("drift_drop", 32'(fx), 7);
        on_log = 1'b1;
        step(); step(); step();
        chk("drift_cleared", 32'(fx), 7);
        log_dir = 1'b1; right = 1'b1;
        step();
        chk("move_then_drift", 32'(fx), 0);
        right = 1'b0; on_log = 1'b0;
        step();

        press(3);
        chk("right_x1", 32'(fx), 1);
        up = 1'b1; left = 1'b1;
        step();
        chk("prio_y", 32'(fy), 4);
        chk("prio_x", 32'(fx), 1);
        up = 1'b0; left = 1'b0;
        step();

        collided = 1'b1;
        step();
        chk("hit_dying", 32'(dying), 1);
        chk("hit_lives", 32'(lives), 1);
        collided = 1'b0; down = 1'b1;
        step();
        chk("dying_2", 32'(dying), 1);
        chk("dying_frozen_y", 32'(fy), 4);
        chk("dying_frozen_x", 32'(fx), 1);
        down = 1'b0;
        step();
        chk("dying_3", 32'(dying), 1);
        step();
        chk("dying_done", 32'(dying), 0);
        chk("respawn_x", 32'(fx), 4);
        chk("respawn_y", 32'(fy), 5);
        chk("respawn_lives", 32'(lives), 1);

        tile = 4'd2;
        step();
        chk("water_dying", 32'(dying), 1);
        chk("water_lives", 32'(lives), 0);
        tile = 4'd0;
        step(); step(); step();
        chk("over_flag", 32'(over), 1);
        chk("over_dying", 32'(dying), 0);
        press(0);
        chk("over_up_ignored", 32'(fy), 5);
        chk("over_held", 32'(over), 1);
        restart = 1'b1;
        step();
        chk("restart_over", 32'(over), 0);
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), 2);
        chk("restart_x", 32'(fx), 4);
        chk("restart_y", 32'(fy), 5);
        restart = 1'b0;
        step();

        tile = 4'd4;
        goal_run();
        step();
        chk("score_one", 32'(score), 1);
        climb(4);
        up = 1'b1;
        step();
        up = 1'b0; collided = 1'b1;
        step();
        chk("death_wins", 32'(dying), 1);
        chk("death_wins_score", 32'(score), 1);
        chk("death_wins_pulse", 32'(pulse), 0);
        chk("death_wins_lives", 32'(lives), 1);
        collided = 1'b0;
        step(); step(); step();
        chk("back_play", 32'(dying), 0);
        chk("back_play_y", 32'(fy), 5);

        for (int i = 0; i < 126; i++) begin
            goal_run();
            step();
        end
        chk("score_max", 32'(score), 127);
        goal_run();
        chk("sat_score", 32'(score), 127);
        chk("sat_pulse", 32'(pulse), 1);
        step();
        tile = 4'd0;

        press(0);
        press(2);
        chk("pre_reset_x", 32'(fx), 3);
        chk("pre_reset_y", 32'(fy), 4);
        collided = 1'b1;
        step();
        collided = 1'b0;
        chk("last_dying", 32'(dying), 1);
        chk("last_lives", 32'(lives), 0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_x", 32'(fx), 4);
        chk("async_y", 32'(fy), 5);
        chk("async_score", 32'(score), 0);
        chk("async_lives", 32'(lives), 2);
        chk("async_dying", 32'(dying), 0);
        chk("async_over", 32'(over), 0);
        chk("async_pulse", 32'(pulse), 0);
        rst_n = 1'b1;
        step(); step(); step(); step();
        chk("post_reset_play", 32'(dying), 0);
        chk("post_reset_over", 32'(over), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
